cp0_unit: RTL
=============

# cp0_unit

Coprocessor 0 for the P7 five-stage MIPS pipeline. It sits in the Memory stage and holds SR (12), Cause (13) and EPC (14). It decides when an exception or interrupt is taken and supplies the mfc0 read value, which travels through the M/W pipeline register into the Writeback stage's CP0 data input. It also supplies the EPC target used by eret.

## Interface
Parameters:
- PRID_VALUE, 32'h0000_2023, read-only PRId contents (used only with CP0_PRID_EN).

Ports:
- clk  in  1  rising-edge clock; sole clock.
- reset  in  1  synchronous, active-high; clears all CP0 state.
- en  in  1  mtc0 write enable from the M-stage instruction.
- CP0Add  in  5  register number for mtc0/mfc0 (rd field).
- CP0In  in  32  mtc0 write data (forwarded rt value).
- VPC  in  32  PC of the M-stage instruction (macroscopic PC).
- BDIn  in  1  M-stage instruction sits in a branch delay slot.
- ExcCodeIn  in  5  pending exception code for the M-stage instruction; 0 = none.
- HWInt  in  6  external interrupt lines (timer0, timer1, interrupt generator, …).
- EXLClr  in  1  eret is in the M stage.
- CP0Out  out  32  combinational read of register CP0Add.
- EPCOut  out  32  current EPC register.
- Req  out  1  combinational; take an exception or interrupt this cycle (flushes the pipeline, forces the PC to 0x0000_4180).

## Operation
- SR fields: IM = [15:10], EXL = [1], IE = [0]. All other SR bits read 0.
- Cause fields: BD = [31], IP = [15:10], ExcCode = [6:2]. All other Cause bits read 0.
- IntReq = (|(HWInt & IM)) & IE & ~EXL.
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq. An interrupt has priority over a synchronous exception.
- Every cycle (not in reset): Cause.IP <= HWInt, unconditionally (including while EXL=1).
- When Req=1, at the next edge:
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - BD <= BDIn.
  - EPC <= BDIn ? VPC-4 : VPC. The subtraction is 32-bit and wraps modulo 2^32.
- When Req=0 and EXLClr=1: EXL <= 0 at the next edge.
- When Req=0, EXLClr=0 and en=1, mtc0 writes by CP0Add:
  - 12: only IM, EXL and IE are updated from CP0In.
  - 14: EPC <= CP0In, all 32 bits.
  - 13: ignored; Cause is not software-writable.
  - Any other address: ignored.
- Simultaneous events:
  - Req with en: the mtc0 is suppressed, because the instruction is being cancelled.
  - Req with EXLClr: Req wins and EXL stays set.
  - EXLClr with en: EXLClr wins for the EXL bit. Other mtc0 fields are written only when EXLClr=0.
- Reads: CP0Out returns SR, Cause or EPC for addresses 12/13/14 and 0 for every other address. Reads reflect register state before the current edge; there is no write-through.

## Timing
- All state updates occur on the rising clk edge. Req, CP0Out and EPCOut are purely combinational from current state and inputs.
- Reset (reset=1 at an edge): SR=0, Cause=0, EPC=0. Therefore Req=0 (IE=0, ExcCodeIn=0 expected), CP0Out=0, EPCOut=0.
- A reset asserted while Req=1 takes precedence: all state clears and the exception is not recorded.
- mtc0 to SR in cycle n: a new IE/IM affects IntReq from cycle n+1.
- EXL is set at the edge where Req=1. Req deasserts in cycle n+1 unless forced by new inputs; with EXL=1 it cannot be forced.
- Interrupt latency: Req rises in the same cycle an enabled HWInt line rises, given IE=1 and EXL=0. Cause.IP shows the line one cycle later.

## Configuration
- CP0_PRID_EN defined: address 15 reads PRID_VALUE, and mtc0 to address 15 is ignored.
- CP0_PRID_EN undefined: address 15 reads 0 like any unimplemented register. PRID_VALUE is unused.

## Test plan
- Reset then read: reset=1 for 1 cycle, then CP0Add=12/13/14 -> CP0Out=0 each, Req=0, EPCOut=0.
- Interrupt entry: mtc0 SR=32'h0000_0401 (IM[10], IE), then HWInt=6'b000001, VPC=32'h0000_3010, BDIn=0 -> Req=1 the same cycle. Next cycle: SR=32'h0000_0403, Cause=32'h0000_0400, EPC=32'h0000_3010, Req=0.
- Delay-slot exception: ExcCodeIn=5'd4 (AdEL), BDIn=1, VPC=32'h0000_3024, EXL=0 -> Req=1. Next cycle: Cause=32'h8000_0010, EPC=32'h0000_3020.
- Masking: EXL=1 with HWInt=6'b111111 and IM all set -> Req=0, but Cause.IP=6'b111111 next cycle. Then EXLClr=1 for one cycle -> EXL=0, and Req=1 in the following cycle.
- Collision: en=1, CP0Add=14, CP0In=32'hDEAD_BEEC together with ExcCodeIn=5'd10, VPC=32'h0000_3000 -> EPC=32'h0000_3000, not DEAD_BEEC, and ExcCode=10.
- Configuration: CP0Add=15 -> CP0Out=PRID_VALUE (32'h0000_2023) with CP0_PRID_EN defined, 0 without it.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor 0 (SR/Cause/EPC) for the M stage: exception/interrupt entry, mtc0/mfc0, eret.
// Optional macro CP0_PRID_EN maps PRID_VALUE onto address 15 (read-only).
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
  assign Req       = w_int_req | w_exc_req;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0,
                    r_exccode, 2'b0};
  assign EPCOut  = r_epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= HWInt;
      // Entry cancels the M-stage instruction, so its mtc0 is dropped
      if (Req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
        r_bd      <= BDIn;
        r_epc     <= BDIn ? VPC - 32'd4 : VPC;
      end else if (EXLClr) begin
        r_exl <= 1'b0;
      end else if (en) begin
        case (CP0Add)
          5'd12: begin
            r_im  <= CP0In[15:10];
            r_exl <= CP0In[1];
            r_ie  <= CP0In[0];
          end
          5'd14:   r_epc <= CP0In;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      5'd12:   CP0Out = w_sr;
      5'd13:   CP0Out = w_cause;
      5'd14:   CP0Out = r_epc;
`ifdef CP0_PRID_EN
      5'd15:   CP0Out = PRID_VALUE;
`endif
      default: CP0Out = '0;
    endcase
  end

`ifdef CP0_PRID_EN
  logic w_unused;
  assign w_unused = &{1'b0, CP0In[31:16], CP0In[9:2]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, CP0In[31:16], CP0In[9:2],
                      PRID_VALUE};
`endif

endmodule
